// File: rtl/sprite_sched_pkg.sv
// Shared constants, entity field helpers and FSM states for the sprite line scheduler.
// The optional SPRITE_SCHED_COLLISION_EN build adds a collision pulse output.
package sprite_sched_pkg;

  localparam int H_VISIBLE     = 640;
  localparam int H_TOTAL       = 800;
  localparam int V_VISIBLE     = 480;
  localparam int V_TOTAL       = 525;
  localparam int FETCH_START_H = 640;
  localparam int TILE_PX       = 40;
  localparam int UPSCALE       = 5;
  localparam int TILES_H       = 16;
  localparam int TILES_V       = 12;
  localparam int NUM_SLOTS     = 9;

  localparam logic [3:0] ID_UNUSED = 4'hF;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, READY} state_e;

  function automatic logic [3:0] ent_id(input logic [13:0] e);
    return e[13:10];
  endfunction

  function automatic logic [1:0] ent_orient(input logic [13:0] e);
    return e[9:8];
  endfunction

  function automatic logic [7:0] ent_loc(input logic [13:0] e);
    return e[7:0];
  endfunction

  function automatic logic [3:0] ent_col(input logic [13:0] e);
    return e[3:0];
  endfunction

  function automatic logic [3:0] ent_row(input logic [13:0] e);
    return e[7:4];
  endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-buffered 16-tile sprite row store with per-tile valid bits and write-if-empty.
// Under SPRITE_SCHED_COLLISION_EN it also flags writes that hit an occupied tile.
module sprite_line_buffer
  import sprite_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [3:0] wr_col_i,
  input  logic [7:0] wr_data_i,
  input  logic       swap_i,
  input  logic       clear_i,
  input  logic [3:0] rd_col_i,
  input  logic [2:0] rd_bit_i,
  output logic       rd_valid_o,
  output logic       rd_bit_o
`ifdef SPRITE_SCHED_COLLISION_EN
  , output logic     wr_conflict_o
`endif
);

  logic                         front_q;
  logic [1:0][TILES_H-1:0]      vld_q;
  logic [1:0][TILES_H-1:0][7:0] mem_q;
  logic                         back;
  logic                         wr_ok;

  assign back  = ~front_q;
  // First writer to a tile owns it for the line; later writes are dropped.
  assign wr_ok = wr_en_i && !swap_i && !clear_i && !vld_q[back][wr_col_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q <= 1'b0;
      vld_q   <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
    end else if (swap_i) begin
      front_q        <= back;
      vld_q[front_q] <= '0;
    end else if (wr_ok) begin
      vld_q[back][wr_col_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[back][wr_col_i] <= wr_data_i;
  end

  assign rd_valid_o = vld_q[front_q][rd_col_i];
  assign rd_bit_o   = mem_q[front_q][rd_col_i][rd_bit_i];

`ifdef SPRITE_SCHED_COLLISION_EN
  assign wr_conflict_o = wr_en_i && vld_q[back][wr_col_i];
`endif

endmodule

// File: rtl/sprite_line_scheduler.sv
// Fetches one SpriteROM row per entity during h-blank and serialises the line buffer to colour.
// Define SPRITE_SCHED_COLLISION_EN to add the collision output.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] entity_1,
  input  logic [13:0] entity_2,
  input  logic [13:0] entity_3,
  input  logic [13:0] entity_4,
  input  logic [13:0] entity_5,
  input  logic [13:0] entity_6,
  input  logic [13:0] entity_7,
  input  logic [13:0] entity_8,
  input  logic [13:0] entity_9,
  input  logic [9:0]  counter_V,
  input  logic [9:0]  counter_H,
  output logic [3:0]  rom_charc,
  output logic [1:0]  rom_direction,
  output logic [2:0]  rom_index,
  input  logic [7:0]  rom_data,
  output logic        colour,
  output logic        busy
`ifdef SPRITE_SCHED_COLLISION_EN
  , output logic      collision
`endif
);

  logic [NUM_SLOTS-1:0][13:0] ent_in;
  logic [NUM_SLOTS-1:0][13:0] snap_q, snap_d;
  state_e                     state_q, state_d;
  logic [3:0]                 slot_q, slot_d;
  logic [9:0]                 nl_q, nl_d, nl_next;
  logic                       cap_vld_q, cap_vld_d;
  logic [3:0]                 cap_col_q, cap_col_d;
  logic                       colour_q, colour_d;
  logic [13:0]                cur;
  logic [3:0]                 tile_row;
  logic [2:0]                 spr_row;
  logic                       qualify;
  logic                       swap, clear;
  logic [3:0]                 pix_col;
  logic [2:0]                 pix_bit;
  logic                       blank;
  logic                       rd_valid, rd_bit;
`ifdef SPRITE_SCHED_COLLISION_EN
  logic                       coll_seen_q, coll_seen_d;
  logic                       wr_conflict;
`endif

  assign ent_in = {entity_9, entity_8, entity_7, entity_6, entity_5,
                   entity_4, entity_3, entity_2, entity_1};

  assign nl_next  = (counter_V == 10'(V_TOTAL-1)) ? 10'd0 : counter_V + 10'd1;
  assign tile_row = 4'(nl_q / 10'(TILE_PX));
  assign spr_row  = 3'((nl_q % 10'(TILE_PX)) / 10'(UPSCALE));

  assign cur     = snap_q[slot_q];
  assign qualify = (state_q == SCAN) && (ent_id(cur) != ID_UNUSED) &&
                   (ent_loc(cur) < 8'(TILES_H*TILES_V)) && (ent_row(cur) == tile_row);

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    snap_d        = snap_q;
    nl_d          = nl_q;
    cap_vld_d     = 1'b0;
    cap_col_d     = cap_col_q;
    swap          = 1'b0;
    clear         = 1'b0;
    busy          = 1'b0;
    rom_charc     = ID_UNUSED;
    rom_direction = 2'd0;
    rom_index     = 3'd0;
`ifdef SPRITE_SCHED_COLLISION_EN
    coll_seen_d   = coll_seen_q;
    if (cap_vld_q && wr_conflict) coll_seen_d = 1'b1;
`endif

    if (qualify) begin
      rom_charc     = ent_id(cur);
      rom_direction = ent_orient(cur);
      rom_index     = spr_row;
      cap_vld_d     = 1'b1;
      cap_col_d     = ent_col(cur);
    end

    case (state_q)
      IDLE: if (counter_H == 10'(FETCH_START_H)) begin
        busy    = 1'b1;
        snap_d  = ent_in;
        nl_d    = nl_next;
        slot_d  = 4'd0;
        state_d = (nl_next >= 10'(V_VISIBLE)) ? READY : SCAN;
`ifdef SPRITE_SCHED_COLLISION_EN
        coll_seen_d = 1'b0;
`endif
      end
      SCAN: begin
        busy = 1'b1;
        if (slot_q == 4'(NUM_SLOTS-1)) state_d = DRAIN;
        else                           slot_d  = slot_q + 4'd1;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = READY;
      end
      READY: ;
    endcase

    // End of line: publish a finished fetch, otherwise drop everything.
    if (counter_H == 10'(H_TOTAL-1)) begin
      state_d   = IDLE;
      cap_vld_d = 1'b0;
      if (state_q == READY) swap  = 1'b1;
      else                  clear = 1'b1;
`ifdef SPRITE_SCHED_COLLISION_EN
      coll_seen_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= 4'd0;
      snap_q    <= '0;
      nl_q      <= 10'd0;
      cap_vld_q <= 1'b0;
      cap_col_q <= 4'd0;
      colour_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      snap_q    <= snap_d;
      nl_q      <= nl_d;
      cap_vld_q <= cap_vld_d;
      cap_col_q <= cap_col_d;
      colour_q  <= colour_d;
    end
  end

`ifdef SPRITE_SCHED_COLLISION_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) coll_seen_q <= 1'b0;
    else       coll_seen_q <= coll_seen_d;
  end

  assign collision = (counter_H == 10'(H_TOTAL-1)) && (state_q == READY) && coll_seen_q;
`endif

  sprite_line_buffer u_buf (
    .clk        (clk),
    .rst        (reset),
    .wr_en_i    (cap_vld_q),
    .wr_col_i   (cap_col_q),
    .wr_data_i  (rom_data),
    .swap_i     (swap),
    .clear_i    (clear),
    .rd_col_i   (pix_col),
    .rd_bit_i   (pix_bit),
    .rd_valid_o (rd_valid),
    .rd_bit_o   (rd_bit)
`ifdef SPRITE_SCHED_COLLISION_EN
    , .wr_conflict_o (wr_conflict)
`endif
  );

  assign pix_col = 4'(counter_H / 10'(TILE_PX));
  assign pix_bit = 3'((counter_H % 10'(TILE_PX)) / 10'(UPSCALE));
  assign blank   = (counter_H >= 10'(H_VISIBLE)) || (counter_V >= 10'(V_VISIBLE));

  // Empty tiles show the white background.
  assign colour_d = blank ? 1'b0 : (rd_valid ? rd_bit : 1'b1);
  assign colour   = colour_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboarded bench for sprite_line_scheduler; honours SPRITE_SCHED_COLLISION_EN.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] ent [9];
  logic [9:0]  counter_V, counter_H;
  logic [3:0]  rom_charc;
  logic [1:0]  rom_direction;
  logic [2:0]  rom_index;
  logic [7:0]  rom_data = 8'h00;
  logic        colour, busy;
`ifdef SPRITE_SCHED_COLLISION_EN
  logic        collision;
  int          coll_cnt, coll_h;
`endif

  typedef struct {logic exp; int v; int h;} sb_t;
  sb_t sbq[$];

  int n_vec = 0, n_err = 0;
  int busy_cnt, req_cnt;
  logic [3:0] first_charc;
  logic [1:0] first_dir;
  logic [2:0] first_idx;
  logic       exp_v [16];
  logic [7:0] exp_d [16];

  always #5 clk = ~clk;

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset),
    .entity_1(ent[0]), .entity_2(ent[1]), .entity_3(ent[2]),
    .entity_4(ent[3]), .entity_5(ent[4]), .entity_6(ent[5]),
    .entity_7(ent[6]), .entity_8(ent[7]), .entity_9(ent[8]),
    .counter_V(counter_V), .counter_H(counter_H),
    .rom_charc(rom_charc), .rom_direction(rom_direction), .rom_index(rom_index),
    .rom_data(rom_data), .colour(colour), .busy(busy)
`ifdef SPRITE_SCHED_COLLISION_EN
    , .collision(collision)
`endif
  );

  // SpriteROM stand-in: one-cycle read latency, content keyed on character.
  function automatic logic [7:0] rom_fn(input logic [3:0] c);
    case (c)
      4'h2:    return 8'h03;
      4'h3:    return 8'hFF;
      4'h7:    return 8'h00;
      default: return 8'hA5;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_charc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_pix(input int v, input int h);
    int c, b;
    logic [7:0] d;
    if (h >= 640 || v >= 480) return 1'b0;
    c = h / 40;
    b = (h % 40) / 5;
    d = exp_d[c];
    return exp_v[c] ? d[b] : 1'b1;
  endfunction

  task automatic clr_img();
    for (int i = 0; i < 16; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 8'h00;
    end
  endtask

  task automatic set_ent(input int k, input logic [3:0] id, input logic [1:0] o, input logic [7:0] loc);
    ent[k] = {id, o, loc};
  endtask

  task automatic all_unused();
    for (int i = 0; i < 9; i++) ent[i] = {4'hF, 2'b00, 8'd0};
  endtask

  task automatic step(input int v, input int h, input bit sb);
    sb_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("colour v%0d h%0d", e.v, e.h), colour, e.exp);
    end
    counter_V = 10'(v);
    counter_H = 10'(h);
    if (sb) begin
      e.exp = exp_pix(v, h);
      e.v   = v;
      e.h   = h;
      sbq.push_back(e);
    end
    #1;
    if (busy) busy_cnt++;
    if (rom_charc != 4'hF) req_cnt++;
    if (h == 641) begin
      first_charc = rom_charc;
      first_dir   = rom_direction;
      first_idx   = rom_index;
    end
`ifdef SPRITE_SCHED_COLLISION_EN
    if (collision) begin
      coll_cnt++;
      coll_h = h;
    end
`endif
  endtask

  // scramble: rewrite every entity mid-scan to show only the snapshot matters
  task automatic run_line(input int v, input bit sb, input bit overrun, input bit scramble);
    busy_cnt    = 0;
    req_cnt     = 0;
    first_charc = 4'hF;
`ifdef SPRITE_SCHED_COLLISION_EN
    coll_cnt = 0;
    coll_h   = -1;
`endif
    for (int h = 0; h < 800; h++) begin
      if (overrun && h > 643 && h < 799) continue;
      step(v, h, sb);
      if (scramble && h == 641)
        for (int i = 0; i < 9; i++) set_ent(i, 4'h9, 2'b00, 8'd17);
    end
  endtask

  initial begin
    reset     = 1'b1;
    counter_V = 10'd0;
    counter_H = 10'd0;
    all_unused();
    clr_img();
    repeat (2) @(posedge clk);
    #1;
    chk("rst colour", colour, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst charc", rom_charc, 4'hF);
    chk("rst dir", rom_direction, 2'd0);
    chk("rst idx", rom_index, 3'd0);
    reset = 1'b0;

    // Single sprite at tile (1,1), ROM row 8'b00000011.
    set_ent(0, 4'h2, 2'b01, 8'd17);
    run_line(44, 0, 0, 1);
    chk("t1 charc", first_charc, 4'h2);
    chk("t1 dir", first_dir, 2'd1);
    chk("t1 idx", first_idx, 3'd1);
    chk("t1 busy cycles", busy_cnt, 11);
    all_unused();
    clr_img();
    exp_v[1] = 1'b1;
    exp_d[1] = 8'h03;
    run_line(45, 1, 0, 0);

    // Two slots on the same tile: the lower slot owns it.
    all_unused();
    set_ent(2, 4'h3, 2'b00, 8'd5);
    set_ent(6, 4'h7, 2'b00, 8'd5);
    run_line(10, 0, 0, 0);
    chk("t2 idx", req_cnt, 2);
`ifdef SPRITE_SCHED_COLLISION_EN
    chk("t2 coll count", coll_cnt, 1);
    chk("t2 coll h", coll_h, 799);
`endif
    all_unused();
    clr_img();
    exp_v[5] = 1'b1;
    exp_d[5] = 8'hFF;
    run_line(11, 1, 0, 0);
`ifdef SPRITE_SCHED_COLLISION_EN
    chk("t2 no coll", coll_cnt, 0);
`endif

    // Off-grid location is ignored.
    all_unused();
    set_ent(4, 4'h4, 2'b00, 8'd200);
    run_line(20, 0, 0, 0);
    chk("t3 no req", req_cnt, 0);
    all_unused();
    clr_img();
    run_line(21, 1, 0, 0);

    // Frame wrap: last line fetches line 0.
    set_ent(0, 4'h5, 2'b10, 8'd3);
    run_line(524, 0, 0, 0);
    chk("t4 charc", first_charc, 4'h5);
    chk("t4 dir", first_dir, 2'd2);
    chk("t4 idx", first_idx, 3'd0);
    all_unused();
    clr_img();
    exp_v[3] = 1'b1;
    exp_d[3] = 8'hA5;
    run_line(0, 1, 0, 0);

    // Next line off-screen: no fetch, one busy cycle, black line.
    set_ent(0, 4'h5, 2'b10, 8'd3);
    run_line(479, 0, 0, 0);
    chk("t5 busy cycles", busy_cnt, 1);
    chk("t5 no req", req_cnt, 0);
    clr_img();
    run_line(480, 1, 0, 0);

    // Reset in the middle of a scan.
    all_unused();
    set_ent(0, 4'h2, 2'b01, 8'd17);
    run_line(44, 0, 0, 0);
    for (int h = 0; h <= 645; h++) step(45, h, 0);
    chk("t6 busy pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6 busy rst", busy, 1'b0);
    chk("t6 colour rst", colour, 1'b0);
    chk("t6 charc rst", rom_charc, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    all_unused();
    set_ent(1, 4'h6, 2'b00, 8'd22);
    run_line(45, 0, 0, 0);
    chk("t6 busy cycles", busy_cnt, 11);
    all_unused();
    clr_img();
    exp_v[6] = 1'b1;
    exp_d[6] = 8'hA5;
    run_line(46, 1, 0, 0);

    // Overrun: line ends while still scanning.
    set_ent(0, 4'h2, 2'b01, 8'd17);
    run_line(44, 0, 0, 0);
    clr_img();
    exp_v[1] = 1'b1;
    exp_d[1] = 8'h03;
    run_line(45, 1, 1, 0);
    all_unused();
    clr_img();
    run_line(46, 1, 0, 0);
    chk("t7 busy cycles", busy_cnt, 11);

    step(47, 0, 0);
    chk("sb drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
